// File: rtl/m_player_seq.sv
// m_player_seq: multi-song score sequencer and square-wave tone generator; define M_PLAYER_SEQ_GAP_EN to silence the tail of each note.
module m_player_seq #(
  parameter int CLK_HZ = 1_000_000,
  parameter int BEAT_HZ = 4,
  parameter int SONG_NUM = 2,
  parameter int SONG_AW = 7,
  parameter int DIV_W = 16,
  localparam int SI_W = SONG_NUM > 1 ? $clog2(SONG_NUM) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    play,
  input  logic                    next_song,
  input  logic                    loop_en,
  output logic [SI_W+SONG_AW-1:0] rom_addr,
  input  logic [7:0]              rom_data,
  output logic [5:0]              note_code,
  output logic [SI_W-1:0]         song_idx,
  output logic                    playing,
  output logic                    beep
);
  localparam int BEAT_CYC = CLK_HZ / BEAT_HZ;
  localparam int BW = BEAT_CYC > 1 ? $clog2(BEAT_CYC) : 1;
  localparam int FREQ [7] = '{262, 294, 330, 349, 392, 440, 494};
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DECODE, PLAY} state_t;
  state_t state, state_n;
  logic [SONG_AW-1:0] offset;
  logic [1:0] len, beats;
  logic [BW-1:0] beat_cnt;
  logic [DIV_W-1:0] tone_cnt, hp;
  logic [5:0] note;
  logic tone, is_note, gap;
  logic [DIV_W-1:0] hp_tab [4][8];
  if (SONG_NUM < 1) begin : g_bad_songs
    $error("SONG_NUM must be at least 1");
  end
  if (((CLK_HZ / 524) >> DIV_W) != 0) begin : g_bad_div
    $error("tone half-period does not fit in DIV_W bits");
  end
  for (genvar o = 0; o < 4; o++) begin : g_o
    for (genvar d = 0; d < 8; d++) begin : g_d
      if (o == 0 || d == 0) begin : g_z
        assign hp_tab[o][d] = '0;
      end else begin : g_n
        assign hp_tab[o][d] = DIV_W'(CLK_HZ / (2 * FREQ[d-1] * (1 << (o - 1))));
      end
    end
  end
  wire [1:0] oct = rom_data[7:6];
  wire [3:0] deg = rom_data[3:0];
  wire note_ok = oct != 2'd0 && deg != 4'd0 && !deg[3];
  wire is_end = oct == 2'd0 && deg == 4'hF;
  wire beat_end = beat_cnt == BW'(BEAT_CYC - 1);
  wire note_end = beat_end && beats == len;
  wire [SI_W-1:0] song_inc = song_idx == SI_W'(SONG_NUM - 1) ? '0 : song_idx + 1'b1;
  wire tone_wrap = tone_cnt == hp - 1'b1;
`ifdef M_PLAYER_SEQ_GAP_EN
  assign gap = beats == len && beat_cnt >= BW'(BEAT_CYC - BEAT_CYC / 8);
`else
  assign gap = 1'b0;
`endif
  assign rom_addr = {song_idx, offset};
  assign playing = state == PLAY && play;
  assign note_code = playing ? note : '0;
  assign beep = tone && playing && !gap;
  always_ff @(posedge CLK)
    state <= RST ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (next_song && state != IDLE) state_n = FETCH;
    else if (play)
      case (state)
        IDLE:    state_n = FETCH;
        FETCH:   state_n = WAIT;
        WAIT:    state_n = DECODE;
        DECODE:  state_n = is_end ? FETCH : PLAY;
        PLAY:    state_n = note_end ? FETCH : PLAY;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      song_idx <= '0;
      offset <= '0;
      len <= '0;
      beats <= '0;
      beat_cnt <= '0;
      tone_cnt <= '0;
      hp <= '0;
      note <= '0;
      tone <= 1'b0;
      is_note <= 1'b0;
    end else if (next_song) begin
      song_idx <= song_inc;
      if (state != IDLE) begin
        offset <= '0;
        tone <= 1'b0;
        tone_cnt <= '0;
        beat_cnt <= '0;
        beats <= '0;
      end
    end else if (play) begin
      if (state == DECODE) begin
        tone <= 1'b0;
        tone_cnt <= '0;
        beat_cnt <= '0;
        beats <= '0;
        len <= rom_data[5:4];
        note <= note_ok ? {oct, deg} : '0;
        is_note <= note_ok;
        hp <= hp_tab[oct][deg[2:0]];
        if (is_end) begin
          offset <= '0;
          if (!loop_en) song_idx <= song_inc;
        end
      end
      if (state == PLAY) begin
        beat_cnt <= beat_end ? '0 : beat_cnt + 1'b1;
        if (beat_end) beats <= beats + 1'b1;
        if (note_end) begin
          offset <= offset + 1'b1;
          if (&offset && !loop_en) song_idx <= song_inc;
        end
        if (is_note) begin
          tone_cnt <= tone_wrap ? '0 : tone_cnt + 1'b1;
          if (tone_wrap) tone <= ~tone;
        end
      end
    end
  end
endmodule

// File: tb/tb_m_player_seq.sv
// tb_m_player_seq: directed checks of sequencing, durations, end handling, pause and skip.
module tb_m_player_seq;
`ifdef M_PLAYER_SEQ_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif
  localparam int CODES [8] = '{'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h31};
  logic clk = 1'b0, rst, play, next_song, loop_en;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [5:0] note_code;
  logic [0:0] song_idx;
  logic playing, beep;
  logic [7:0] rom [16];
  int n_cmp = 0, n_err = 0;
  m_player_seq #(.CLK_HZ(8000), .BEAT_HZ(100), .SONG_NUM(2), .SONG_AW(3), .DIV_W(16)) dut (
    .CLK(clk), .RST(rst), .play(play), .next_song(next_song), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .note_code(note_code),
    .song_idx(song_idx), .playing(playing), .beep(beep)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clear_rom;
    for (int i = 0; i < 16; i++) rom[i] = 8'h0F;
  endtask
  task automatic run_note(input string tag, input int code, input int hp, input int total);
    for (int k = 0; k < total; k++) begin
      bit eb;
      eb = hp != 0 && ((k / hp) % 2 == 1) && !(GAP && k >= total - 10);
      check({tag, " playing"}, int'(playing), 1);
      check({tag, " note_code"}, int'(note_code), code);
      check({tag, " beep"}, int'(beep), int'(eb));
      tick(1);
    end
  endtask
  initial begin
    rst = 1'b1; play = 1'b0; next_song = 1'b0; loop_en = 1'b1;
    clear_rom;
    tick(2);
    check("rst rom_addr", int'(rom_addr), 0);
    check("rst note_code", int'(note_code), 0);
    check("rst song_idx", int'(song_idx), 0);
    check("rst playing", int'(playing), 0);
    check("rst beep", int'(beep), 0);
    rst = 1'b0;
    next_song = 1'b1;
    tick(1);
    next_song = 1'b0;
    check("idle skip song", int'(song_idx), 1);
    check("idle skip addr", int'(rom_addr), 8);
    tick(3);
    check("idle stays addr", int'(rom_addr), 8);
    check("idle stays playing", int'(playing), 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst2 song_idx", int'(song_idx), 0);
    rom[0] = 8'h86; rom[1] = 8'h71; rom[2] = 8'h30; rom[3] = 8'h0F;
    play = 1'b1;
    tick(3);
    check("start decode playing", int'(playing), 0);
    check("start decode addr", int'(rom_addr), 0);
    tick(1);
    run_note("midA", 'h26, 4, 80);
    check("midA next addr", int'(rom_addr), 1);
    check("gap fetch beep", int'(beep), 0);
    tick(1);
    check("gap wait beep", int'(beep), 0);
    tick(1);
    check("gap decode beep", int'(beep), 0);
    check("gap decode playing", int'(playing), 0);
    tick(1);
    run_note("lowC", 'h11, 15, 320);
    check("lowC next addr", int'(rom_addr), 2);
    tick(3);
    run_note("rest", 0, 0, 320);
    check("rest next addr", int'(rom_addr), 3);
    tick(2);
    check("end decode addr", int'(rom_addr), 3);
    tick(1);
    check("loop addr", int'(rom_addr), 0);
    check("loop song", int'(song_idx), 0);
    tick(3);
    check("loop replay playing", int'(playing), 1);
    check("loop replay code", int'(note_code), 'h26);
    rst = 1'b1;
    clear_rom;
    rom[0] = 8'h86; rom[1] = 8'h86; rom[2] = 8'h0F;
    for (int j = 0; j < 7; j++) rom[8 + j] = 8'h81 + 8'(j);
    rom[15] = 8'hC1;
    loop_en = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(84);
    check("s0 second addr", int'(rom_addr), 1);
    tick(85);
    check("s0 end decode addr", int'(rom_addr), 2);
    tick(1);
    check("end adv addr", int'(rom_addr), 8);
    check("end adv song", int'(song_idx), 1);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("wrap fetch addr %0d", j), int'(rom_addr), 8 + j);
      tick(3);
      check($sformatf("wrap code %0d", j), int'(note_code), CODES[j]);
      check($sformatf("wrap playing %0d", j), int'(playing), 1);
      tick(80);
    end
    check("wrap addr", int'(rom_addr), 0);
    check("wrap song", int'(song_idx), 0);
    rst = 1'b1;
    clear_rom;
    rom[0] = 8'h86; rom[1] = 8'h86; rom[2] = 8'h0F; rom[8] = 8'h86;
    tick(1);
    rst = 1'b0;
    tick(24);
    check("pre-pause beep", int'(beep), 1);
    play = 1'b0;
    tick(1);
    check("pause playing", int'(playing), 0);
    check("pause beep", int'(beep), 0);
    check("pause code", int'(note_code), 0);
    tick(49);
    check("pause hold beep", int'(beep), 0);
    check("pause hold addr", int'(rom_addr), 0);
    play = 1'b1;
    tick(1);
    check("resume beep", int'(beep), 1);
    check("resume playing", int'(playing), 1);
    tick(5);
    check("resume phase beep", int'(beep), 0);
    tick(53);
    check("resume last playing", int'(playing), 1);
    check("resume last addr", int'(rom_addr), 0);
    tick(1);
    check("resume expiry addr", int'(rom_addr), 1);
    tick(84);
    check("end wait addr", int'(rom_addr), 2);
    next_song = 1'b1;
    tick(1);
    next_song = 1'b0;
    check("skip+end song", int'(song_idx), 1);
    check("skip+end addr", int'(rom_addr), 8);
    tick(3);
    check("s1 playing", int'(playing), 1);
    tick(12);
    check("s1 beep", int'(beep), 1);
    rst = 1'b1;
    tick(1);
    check("midrst beep", int'(beep), 0);
    check("midrst playing", int'(playing), 0);
    check("midrst song", int'(song_idx), 0);
    check("midrst addr", int'(rom_addr), 0);
    check("midrst code", int'(note_code), 0);
    rst = 1'b0;
    tick(4);
    check("restart code", int'(note_code), 'h26);
    tick(6);
    next_song = 1'b1;
    tick(1);
    next_song = 1'b0;
    check("abort beep", int'(beep), 0);
    check("abort playing", int'(playing), 0);
    check("abort addr", int'(rom_addr), 8);
    check("abort song", int'(song_idx), 1);
    play = 1'b0;
    next_song = 1'b1;
    tick(1);
    next_song = 1'b0;
    check("skip+pause song", int'(song_idx), 0);
    check("skip+pause addr", int'(rom_addr), 0);
    tick(5);
    check("paused fetch addr", int'(rom_addr), 0);
    check("paused fetch playing", int'(playing), 0);
    play = 1'b1;
    tick(3);
    check("unpause playing", int'(playing), 1);
    check("unpause code", int'(note_code), 'h26);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
